// File: rtl/cookie_pkg.sv
// cookie_pkg: shared FSM state type and default sizing for the cookie jar.
package cookie_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FAIL} state_t;
  localparam int WORD_W_D = 8;
  localparam int FIFO_DEPTH_D = 4;
  localparam int REP_LIMIT_D = 16;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/cookie_jar_fifo.sv
// cookie_jar_fifo: flushable synchronous FIFO with a registered head word.
module cookie_jar_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd, wr_n, rd_n;
  logic do_push, do_pop;
  always_comb begin
    empty = wr == rd;
    full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    do_push = push && (!full || pop) && !flush;
    do_pop = pop && !empty && !flush;
    wr_n = wr + PW'(do_push);
    rd_n = rd + PW'(do_pop);
  end
  // head is refreshed from the post-update pointers; a word pushed into an empty slot bypasses mem
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      head_data <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      head_data <= '0;
    end else begin
      wr <= wr_n;
      rd <= rd_n;
      if (rd_n != wr_n) head_data <= (do_push && rd_n == wr) ? push_data : mem[rd_n[AW-1:0]];
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr[AW-1:0]] <= push_data;
endmodule

// File: rtl/cookie_jar.sv
// cookie_jar: samples the cookie random-bit chain, health-tests, debiases, packs and buffers words.
module cookie_jar import cookie_pkg::*; #(
  parameter int WORD_W = WORD_W_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  parameter int REP_LIMIT = REP_LIMIT_D,
  parameter bit VN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rbit,
  input  logic              clear_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              health_fail_o,
  output logic              overflow_o
);
  localparam int CW = $clog2(WORD_W);
  localparam int RW = $clog2(REP_LIMIT + 1);
  state_t state;
  logic [SYNC_STAGES-1:0] sync, en_d;
  logic [WORD_W-2:0] shreg;
  logic [WORD_W-1:0] word_n;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rep_cnt, rep_n;
  logic prev, vn_have, vn_first;
  logic raw, sample, trip, acc, bit_v, push, pop, flush, empty, full;
  always_comb begin
    raw = sync[SYNC_STAGES-1];
    sample = state == RUN && en_d[SYNC_STAGES-1];
    rep_n = (rep_cnt == '0 || raw != prev) ? RW'(1) : rep_cnt + RW'(1);
    trip = sample && rep_n == RW'(REP_LIMIT);
    acc = VN_EN ? vn_have && vn_first != raw : 1'b1;
    bit_v = VN_EN ? vn_first : raw;
    word_n = {shreg, bit_v};
    push = sample && !trip && acc && cnt == CW'(WORD_W - 1);
    pop = valid_o && ready_i;
    flush = clear_i || trip;
  end
  assign valid_o = !empty && state != FAIL;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sync <= '0;
      en_d <= '0;
      shreg <= '0;
      cnt <= '0;
      rep_cnt <= '0;
      prev <= 1'b0;
      vn_have <= 1'b0;
      vn_first <= 1'b0;
      health_fail_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rbit};
      en_d <= {en_d[SYNC_STAGES-2:0], en};
      if (clear_i) begin
        state <= IDLE;
        shreg <= '0;
        cnt <= '0;
        rep_cnt <= '0;
        prev <= 1'b0;
        vn_have <= 1'b0;
        vn_first <= 1'b0;
        health_fail_o <= 1'b0;
        overflow_o <= 1'b0;
      end else if (trip) begin
        state <= FAIL;
        health_fail_o <= 1'b1;
        shreg <= '0;
        cnt <= '0;
        rep_cnt <= rep_n;
      end else begin
        if (push && full && !pop) overflow_o <= 1'b1;
        if (state == IDLE && en) state <= RUN;
        else if (state == RUN && !en) state <= IDLE;
        // leaving RUN drops any half-formed pair; the partial word is kept
        if (state == IDLE) vn_have <= 1'b0;
        if (sample) begin
          rep_cnt <= rep_n;
          prev <= raw;
          vn_have <= VN_EN && !vn_have;
          if (!vn_have) vn_first <= raw;
          if (acc) begin
            shreg <= word_n[WORD_W-2:0];
            cnt <= push ? '0 : cnt + CW'(1);
          end
        end
      end
    end
  cookie_jar_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(push),
    .push_data(word_n),
    .pop(pop),
    .head_data(data_o),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_cookie_jar.sv
// tb_cookie_jar: two jars (plain and von Neumann) fed the same stream, checked by a queue scoreboard.
module tb_cookie_jar;
  import cookie_pkg::*;
  localparam int REP = REP_LIMIT_D;
  logic clk = 0, rst = 1, en = 0, rbit = 0, clear_i = 0;
  logic [1:0] ready = 2'b00;
  logic [7:0] data [2];
  logic [1:0] valid, hf, ovf;
  int total = 0, bad = 0;
  int acc_w[2], nb[2], rep[2], grun;
  bit prv[2], have[2], first[2], failed[2], exp_ovf[2];
  bit gprev, hold, pulse, rnd_ready;
  logic [7:0] q[2][$];
  bit s[$];

  always #5 clk = ~clk;

  cookie_jar #(.VN_EN(1'b0)) d0 (.clk(clk), .rst(rst), .en(en), .rbit(rbit), .clear_i(clear_i),
    .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready[0]), .health_fail_o(hf[0]), .overflow_o(ovf[0]));
  cookie_jar #(.VN_EN(1'b1)) d1 (.clk(clk), .rst(rst), .en(en), .rbit(rbit), .clear_i(clear_i),
    .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready[1]), .health_fail_o(hf[1]), .overflow_o(ovf[1]));

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // monitor: every handshake the DUT offers must match the oldest expected word
  always @(negedge clk)
    if (!rst && !clear_i)
      for (int i = 0; i < 2; i++)
        if (valid[i] && ready[i]) begin
          if (q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop%0d actual=%0h required=none", i, data[i]);
          end else chk($sformatf("pop%0d", i), data[i], q[i].pop_front());
        end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) ready = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      acc_w[i] = 0; nb[i] = 0; rep[i] = 0; prv[i] = 0; have[i] = 0; first[i] = 0;
      failed[i] = 0; exp_ovf[i] = 0; q[i].delete();
    end
    grun = 0; gprev = 0;
  endtask

  task automatic model_bit(input int i, input bit b);
    bit a;
    if (failed[i]) return;
    rep[i] = (rep[i] == 0 || b != prv[i]) ? 1 : rep[i] + 1;
    prv[i] = b;
    if (rep[i] == REP) begin
      failed[i] = 1; nb[i] = 0; acc_w[i] = 0; q[i].delete();
      return;
    end
    if (i == 1) begin
      if (!have[i]) begin have[i] = 1; first[i] = b; return; end
      have[i] = 0;
      if (first[i] == b) return;
      a = first[i];
    end else a = b;
    acc_w[i] = ((acc_w[i] << 1) | int'(a)) & 'hFF;
    nb[i]++;
    if (nb[i] == 8) begin
      nb[i] = 0;
      if (hold && q[i].size() >= 4 && !(pulse && i == 0)) exp_ovf[i] = 1;
      else q[i].push_back(8'(acc_w[i]));
    end
  endtask

  task automatic feed(input bit b);
    model_bit(0, b);
    model_bit(1, b);
    grun = (grun == 0 || b != gprev) ? 1 : grun + 1;
    gprev = b;
  endtask

  // random bits that never build a run long enough to trip the health test
  task automatic gen_q(input int n);
    int lr = grun;
    bit lp = gprev, b;
    s.delete();
    for (int j = 0; j < n; j++) begin
      b = 1'($urandom);
      if (lr == REP - 1 && b == lp) b = !b;
      lr = (lr == 0 || b != lp) ? 1 : lr + 1;
      lp = b;
      s.push_back(b);
    end
  endtask

  task automatic ones(input int n);
    s.delete();
    for (int j = 0; j < n; j++) s.push_back(1'b1);
  endtask

  // the bit driven in the last en-high cycle is never sampled, so it is left out of the model
  task automatic stream(input bit pl = 0, input bit lat = 0);
    foreach (s[j]) begin en = 1; rbit = s[j]; feed(s[j]); step(); end
    rbit = 1'($urandom);
    step();
    en = 0;
    if (pl) ready[0] = 1;
    if (lat) begin @(negedge clk); chk("latency_early", valid[0], 0); end
    step();
    if (pl) ready[0] = 0;
    if (lat) begin
      @(negedge clk); chk("latency_visible", valid[0], 1);
      step();
      @(negedge clk); chk("latency_popped", valid[0], 0);
    end
    have[0] = 0;
    have[1] = 0;
    repeat (3) step();
  endtask

  task automatic clear();
    clear_i = 1;
    step();
    clear_i = 0;
    mreset();
    repeat (3) step();
  endtask

  task automatic drain(input string n);
    hold = 0; pulse = 0; ready = 2'b11;
    repeat (15) step();
    for (int i = 0; i < 2; i++) chk($sformatf("%s_left%0d", n, i), q[i].size(), 0);
  endtask

  task automatic flags(input string n);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_hf%0d", n, i), hf[i], failed[i]);
      chk($sformatf("%s_ovf%0d", n, i), ovf[i], exp_ovf[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mreset();
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_data%0d", i), data[i], 0);
      chk($sformatf("rst_valid%0d", i), valid[i], 0);
    end
    flags("rst");
    rst = 0;
    repeat (3) step();
    ready = 2'b11;
    s = '{1, 0, 1, 1, 0, 0, 1, 0};
    stream(0, 1);
    clear();
    s = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1};
    stream();
    drain("directed");
    rnd_ready = 1;
    for (int k = 0; k < 5; k++) begin gen_q(60); stream(); end
    rnd_ready = 0;
    drain("random");
    flags("random");
    clear();
    ones(15);
    s.push_back(1'b0);
    stream();
    flags("near_trip");
    ones(16);
    stream();
    flags("trip");
    chk("trip_valid0", valid[0], 0);
    chk("trip_valid1", valid[1], 0);
    en = 1;
    repeat (5) begin rbit = 1'($urandom); step(); end
    en = 0;
    repeat (3) step();
    flags("fail_hold");
    chk("fail_hold_valid", valid, 0);
    clear();
    flags("cleared");
    ready = 2'b00; hold = 1; pulse = 1;
    gen_q(40);
    stream(1);
    flags("full_push_pop");
    drain("full_push_pop");
    clear();
    ready = 2'b00; hold = 1;
    gen_q(200);
    stream();
    flags("overflow");
    drain("overflow");
    ready = 2'b00; hold = 1;
    gen_q(16);
    stream();
    chk("pre_rst_valid0", valid[0], 1);
    en = 1;
    repeat (5) begin rbit = 1'($urandom); step(); end
    #2 rst = 1;
    #1;
    mreset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_data%0d", i), data[i], 0);
      chk($sformatf("arst_valid%0d", i), valid[i], 0);
    end
    flags("arst");
    en = 0; hold = 0;
    step();
    rst = 0;
    repeat (3) step();
    ready = 2'b11;
    s = '{1, 0, 1, 1, 0, 0, 1, 0};
    stream();
    s = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1};
    stream();
    drain("post_rst");
    flags("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
